// File: rtl/execute_md_stage.sv
// MIPS execute stage: forwarding muxes, integer ALU and a
// multi-cycle multiply/divide unit that owns HI/LO.
module execute_md_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1_i,
  input  logic [WIDTH-1:0] rd2_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [WIDTH-1:0] m_fwd_i,
  input  logic [WIDTH-1:0] w_fwd_i,
  input  logic [1:0]       a_sel_i,
  input  logic [1:0]       b_rd_sel_i,
  input  logic [1:0]       rd2_sel_i,
  input  logic             b_imm_sel_i,
  input  logic [3:0]       alu_op_i,
  input  logic [2:0]       md_op_i,
  input  logic [1:0]       res_sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] rd2_fwd_o,
  output logic             busy_o,
  output logic             start_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_hi, r_lo;
  logic [WIDTH-1:0]  r_sh_hi, r_sh_lo;

  logic [WIDTH-1:0]  w_a, w_brd, w_b, w_alu;
  logic [4:0]        w_sh;
  logic              w_busy, w_load, w_done;
  logic              w_mthi, w_mtlo;
  logic [CW-1:0]     w_n;

  function automatic logic [WIDTH-1:0] fwd(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] rd,
    input logic [WIDTH-1:0] m,
    input logic [WIDTH-1:0] w
  );
    case (sel)
      2'b10:   return m;
      2'b01:   return w;
      default: return rd;
    endcase
  endfunction

  assign w_a       = fwd(a_sel_i, rd1_i, m_fwd_i, w_fwd_i);
  assign w_brd     = fwd(b_rd_sel_i, rd2_i, m_fwd_i, w_fwd_i);
  assign rd2_fwd_o = fwd(rd2_sel_i, rd2_i, m_fwd_i, w_fwd_i);
  assign w_b       = b_imm_sel_i ? imm_i : w_brd;
  assign w_sh      = w_a[4:0];

  always_comb begin
    w_alu = '0;
    case (alu_op_i)
      4'd0:  w_alu = w_a + w_b;
      4'd1:  w_alu = w_a - w_b;
      4'd2:  w_alu = w_a | w_b;
      4'd3:  w_alu = w_a & w_b;
      4'd4:  w_alu = w_b << 16;
      4'd5:  w_alu = w_a ^ w_b;
      4'd6:  w_alu = ~(w_a | w_b);
      4'd7:  w_alu = {{(WIDTH-1){1'b0}},
                      $signed(w_a) < $signed(w_b)};
      4'd8:  w_alu = {{(WIDTH-1){1'b0}}, w_a < w_b};
      4'd9:  w_alu = w_b << w_sh;
      4'd10: w_alu = w_b >> w_sh;
      4'd11: w_alu = $signed(w_b) >>> w_sh;
      default: w_alu = '0;
    endcase
  end

  // Multiply: sign- or zero-extend to 2*WIDTH and keep the low half.
  logic               w_smul, w_sdiv;
  logic [2*WIDTH-1:0] w_ax, w_bx, w_prod;
  assign w_smul = (md_op_i == 3'd1);
  assign w_sdiv = (md_op_i == 3'd3);
  assign w_ax   = {{WIDTH{w_smul & w_a[WIDTH-1]}}, w_a};
  assign w_bx   = {{WIDTH{w_smul & w_brd[WIDTH-1]}}, w_brd};
  assign w_prod = w_ax * w_bx;

  // Signed divide through magnitudes; remainder follows dividend.
  logic             w_na, w_nb;
  logic [WIDTH-1:0] w_ma, w_mb, w_q, w_r, w_quo, w_rem;
  assign w_na  = w_sdiv & w_a[WIDTH-1];
  assign w_nb  = w_sdiv & w_brd[WIDTH-1];
  assign w_ma  = w_na ? -w_a : w_a;
  assign w_mb  = w_nb ? -w_brd : w_brd;
  assign w_q   = w_ma / w_mb;
  assign w_r   = w_ma % w_mb;
  assign w_quo = (w_na ^ w_nb) ? -w_q : w_q;
  assign w_rem = w_na ? -w_r : w_r;

  logic [2*WIDTH-1:0] w_md_res;
  always_comb begin
    w_md_res = {r_hi, r_lo};
    case (md_op_i)
      3'd1, 3'd2: w_md_res = w_prod;
      3'd3, 3'd4:
        if (w_brd != '0) w_md_res = {w_rem, w_quo};
      default: w_md_res = {r_hi, r_lo};
    endcase
  end

  assign start_o = (md_op_i >= 3'd1) && (md_op_i <= 3'd4);
  assign w_n     = (md_op_i <= 3'd2) ? CW'(MUL_CYCLES)
                                     : CW'(DIV_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (start_o) w_state_nx = S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_RUN);
    w_load = (r_state == S_IDLE) && start_o;
    w_done = w_busy && (r_cnt == CW'(1));
    w_mthi = (r_state == S_IDLE) && (md_op_i == 3'd5);
    w_mtlo = (r_state == S_IDLE) && (md_op_i == 3'd6);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
    end else begin
      if (w_load) begin
        {r_sh_hi, r_sh_lo} <= w_md_res;
        r_cnt <= w_n;
      end else if (w_busy) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_done) begin
        r_hi <= r_sh_hi;
        r_lo <= r_sh_lo;
      end else begin
        if (w_mthi) r_hi <= w_a;
        if (w_mtlo) r_lo <= w_a;
      end
    end
  end

  assign busy_o = w_busy;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

  always_comb begin
    case (res_sel_i)
      2'b01:   result_o = r_hi;
      2'b10:   result_o = r_lo;
      default: result_o = w_alu;
    endcase
  end

endmodule

// File: tb/tb_execute_md_stage.sv
// Scoreboard bench for execute_md_stage: random ALU/forwarding
// traffic plus multiply/divide sequences against a 64-bit model.
module tb_execute_md_stage;

  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] rd1, rd2, imm, mf, wf;
  logic [1:0]  a_sel, b_rd_sel, rd2_sel, res_sel;
  logic        b_imm;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic [31:0] result, rd2_fwd, hi, lo;
  logic        busy, start;

  execute_md_stage dut (
    .clk(clk), .reset(reset),
    .rd1_i(rd1), .rd2_i(rd2), .imm_i(imm),
    .m_fwd_i(mf), .w_fwd_i(wf),
    .a_sel_i(a_sel), .b_rd_sel_i(b_rd_sel),
    .rd2_sel_i(rd2_sel), .b_imm_sel_i(b_imm),
    .alu_op_i(alu_op), .md_op_i(md_op),
    .res_sel_i(res_sel), .result_o(result),
    .rd2_fwd_o(rd2_fwd), .busy_o(busy),
    .start_o(start), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sel3(logic [1:0] s,
    logic [31:0] r, logic [31:0] m, logic [31:0] w);
    if (s == 2'b10) return m;
    if (s == 2'b01) return w;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(int op,
    logic [31:0] a, logic [31:0] b);
    int ia, ib;
    int unsigned sh;
    ia = a;
    ib = b;
    sh = a % 32;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a | b;
      3: return a & b;
      4: return b * 32'd65536;
      5: return a ^ b;
      6: return ~(a | b);
      7: return (ia < ib) ? 1 : 0;
      8: return (a < b) ? 1 : 0;
      9: return b << sh;
      10: return b >> sh;
      11: return ib >>> sh;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] md_ref(int op,
    logic [31:0] a, logic [31:0] b,
    logic [31:0] h, logic [31:0] l);
    int ia, ib;
    longint sa, sb2, q, r;
    longint unsigned ua, ub;
    ia = a; ib = b; sa = ia; sb2 = ib;
    ua = a; ub = b;
    case (op)
      1: return sa * sb2;
      2: return ua * ub;
      3: begin
        if (b == 0) return {h, l};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (b == 0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {h, l};
    endcase
  endfunction

  // Monitor: counts busy cycles and checks HI/LO when busy falls.
  initial begin
    int   cnt;
    logic prev;
    exp_t e;
    cnt = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt = 0;
        prev = 0;
      end else begin
        if (busy) cnt++;
        else if (prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("md_hi", hi, e.hi);
            chk("md_lo", lo, e.lo);
            chk("busy_cycles", cnt, e.n);
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic idle_in();
    rd1 = 0; rd2 = 0; imm = 0; mf = 0; wf = 0;
    a_sel = 0; b_rd_sel = 0; rd2_sel = 0; res_sel = 0;
    b_imm = 0; alu_op = 0; md_op = 0;
  endtask

  task automatic md_start(int op, logic [31:0] a,
                          logic [31:0] b);
    logic [63:0] e;
    exp_t x;
    @(posedge clk); #1;
    a_sel = 0; b_rd_sel = 0; rd1 = a; rd2 = b;
    b_imm = 1; imm = $urandom; md_op = 3'(op);
    #1 chk("start_o", start, 1);
    e = md_ref(op, a, b, m_hi, m_lo);
    {m_hi, m_lo} = e;
    x.hi = e[63:32];
    x.lo = e[31:0];
    x.n  = (op <= 2) ? 5 : 10;
    sb.push_back(x);
    @(posedge clk); #1;
    md_op = 0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    chk("wait_idle_timeout", done, 1);
    @(negedge clk); #1;
  endtask

  task automatic mt(int op, logic [31:0] v);
    @(posedge clk); #1;
    a_sel = 0; rd1 = v; md_op = 3'(op);
    #1 chk("start_o_mt", start, 0);
    @(posedge clk); #1;
    md_op = 0;
    if (op == 5) begin
      m_hi = v;
      chk("mthi", hi, v);
    end else begin
      m_lo = v;
      chk("mtlo", lo, v);
    end
  endtask

  task automatic chk_res_hilo();
    res_sel = 2'b01;
    #1 chk("res_hi", result, m_hi);
    res_sel = 2'b10;
    #1 chk("res_lo", result, m_lo);
    res_sel = 2'b00;
  endtask

  task automatic alu_chk(string nm);
    logic [31:0] a, brd, b;
    #1;
    a   = sel3(a_sel, rd1, mf, wf);
    brd = sel3(b_rd_sel, rd2, mf, wf);
    b   = b_imm ? imm : brd;
    chk(nm, result, alu_ref(int'(alu_op), a, b));
    chk("rd2_fwd", rd2_fwd, sel3(rd2_sel, rd2, mf, wf));
  endtask

  initial begin
    int op;
    idle_in();
    #2 reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;

    // Directed ALU cases
    @(posedge clk); #1;
    a_sel = 2'b10; mf = 5; rd2 = 3; alu_op = 1;
    #1 chk("sub_fwd", result, 2);
    a_sel = 0; b_imm = 1;
    rd1 = 32'hFFFF_FFFF; imm = 1; alu_op = 7;
    #1 chk("slt", result, 1);
    alu_op = 8;
    #1 chk("sltu", result, 0);
    rd1 = 4; imm = 32'h8000_0000; alu_op = 11;
    #1 chk("sra", result, 32'hF800_0000);
    idle_in();

    // Random ALU and forwarding
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      rd1 = $urandom; rd2 = $urandom; imm = $urandom;
      mf = $urandom; wf = $urandom;
      a_sel = 2'($urandom_range(0, 3));
      b_rd_sel = 2'($urandom_range(0, 3));
      rd2_sel = 2'($urandom_range(0, 3));
      b_imm = 1'($urandom_range(0, 1));
      alu_op = 4'($urandom_range(0, 15));
      res_sel = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      alu_chk("alu_rand");
    end
    idle_in();

    // Directed multiply/divide
    md_start(1, 32'hFFFF_FFFE, 3);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    md_start(2, 32'hFFFF_FFFE, 3);
    wait_idle();
    chk("multu_hi", hi, 2);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    md_start(3, -32'sd7, 2);
    wait_idle();
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk_res_hilo();

    // Divide by zero keeps HI/LO
    mt(5, 32'h11);
    mt(6, 32'h22);
    md_start(4, 32'h1234, 0);
    wait_idle();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // Ops while running are ignored
    md_start(1, 32'hFFFF_FFFE, 3);
    a_sel = 0; rd1 = 32'h1234; md_op = 5;
    @(posedge clk); #1;
    rd2 = 7; rd1 = 100; md_op = 3;
    @(posedge clk); #1;
    md_op = 0;
    wait_idle();
    chk("ign_hi", hi, 32'hFFFF_FFFF);
    chk("ign_lo", lo, 32'hFFFF_FFFA);

    // Random multiply/divide
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      op = $urandom_range(1, 4);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 0;
      if ($urandom_range(0, 3) == 0) b = b % 16;
      if ($urandom_range(0, 4) == 0) mt(5, $urandom);
      md_start(op, a, b);
      wait_idle();
      chk_res_hilo();
    end

    // Reset in busy cycle 3 of a divide
    md_start(3, 1000, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    reset = 0;
    sb.delete();
    m_hi = 0;
    m_lo = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);
    chk("post_rst_busy", busy, 0);

    md_start(2, 32'h0001_0000, 32'h0001_0000);
    wait_idle();
    chk("after_rst_hi", hi, 1);
    chk("after_rst_lo", lo, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
